// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
//   REG_ADDR_W / XLEN   : register-file address and data widths
//   NUM_REGS            : number of architectural registers (width of pend_mask)
//   DEFAULT_DEPTH       : default secondary FIFO depth
//   DEFAULT_MAX_WAIT    : default starvation threshold
//   wb_entry_t          : one buffered secondary result
package wb_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int XLEN             = 32;
    localparam int NUM_REGS         = 1 << REG_ADDR_W;
    localparam int DEFAULT_DEPTH    = 4;
    localparam int DEFAULT_MAX_WAIT = 8;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for secondary writeback results with per-entry live bits.
//   clk, rst    : clock, synchronous active-high reset (empties the buffer)
//   push        : enqueue push_entry at this edge (ignored when full)
//   push_entry  : entry to enqueue
//   pop         : drop the head entry at this edge (ignored when empty)
//   kill_en     : clear live on every entry whose addr == kill_addr,
//   kill_addr     including an entry being pushed at the same edge
//   head        : head entry; head.live is 0 when the buffer is empty
//   empty, full : occupancy flags from the registered count
//   pend_mask   : bit i set when a live entry targets register i (bit 0 never)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    output wb_entry_t             head,
    output logic                  empty,
    output logic                  full,
    output logic [NUM_REGS-1:0]   pend_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0]      tail_ptr_q, tail_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      live_q, live_d;
    logic [REG_ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [REG_ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [XLEN-1:0]       mem_data_q [DEPTH];
    logic [XLEN-1:0]       mem_data_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head.live = !empty && live_q[head_ptr_q];
    assign head.addr = mem_addr_q[head_ptr_q];
    assign head.data = mem_data_q[head_ptr_q];

    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        live_d     = live_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        // Slots outside the occupied range already hold live=0, so the kill
        // can sweep every slot without a range check.
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_addr_q[i] == kill_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        // Clearing live on pop keeps vacant slots out of pend_mask.
        if (pop_ok) begin
            live_d[head_ptr_q] = 1'b0;
            head_ptr_d         = head_ptr_q + PTR_W'(1);
        end

        // A same-edge primary write to the same register makes the new
        // entry stale on arrival: the secondary is always the older result.
        if (push_ok) begin
            mem_addr_d[tail_ptr_q] = push_entry.addr;
            mem_data_d[tail_ptr_q] = push_entry.data;
            live_d[tail_ptr_q]     = push_entry.live &&
                                     !(kill_en && (push_entry.addr == kill_addr));
            tail_ptr_d             = tail_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pend_mask[mem_addr_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
        if (rst) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            live_q     <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
            live_q     <= live_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter owning the single register-file write port.
//   clk, rst          : clock, synchronous active-high reset
//   p_valid/p_addr/
//   p_data            : in-order primary writeback; always wins the port
//   s_valid/s_ready/
//   s_addr/s_data     : long-latency secondary results, buffered in a FIFO
//   werf/wa/wd        : registered register-file write port
//   stall             : registered request to hold the primary off
//   pend_mask         : registers targeted by live buffered results
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_addr,
    input  logic [XLEN-1:0]       p_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [REG_ADDR_W-1:0] s_addr,
    input  logic [XLEN-1:0]       s_data,
    output logic                  werf,
    output logic [REG_ADDR_W-1:0] wa,
    output logic [XLEN-1:0]       wd,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   pend_mask
);

    localparam int STARVE_W = $clog2(MAX_WAIT + 1);

    logic                  werf_q, werf_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [XLEN-1:0]       wd_q, wd_d;
    logic                  stall_q, stall_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;

    wb_entry_t fifo_head;
    wb_entry_t push_entry;
    logic      fifo_empty;
    logic      fifo_full;
    logic      fifo_push;
    logic      fifo_pop;
    logic      p_write;
    logic      pop_live;
    logic      pop_dead;
    logic      head_killed;

    assign p_write = p_valid && (p_addr != '0);

    // s_ready looks only at the registered count, so a pop can never free a
    // slot for a push at the same edge.
    assign s_ready   = !fifo_full && !rst;
    assign fifo_push = s_valid && s_ready && (s_addr != '0);

    assign push_entry.live = 1'b1;
    assign push_entry.addr = s_addr;
    assign push_entry.data = s_data;

    // The live head drains only when the primary leaves the port free; a
    // killed head costs no write slot and is dropped at any edge.
    assign pop_live    = fifo_head.live && !p_write;
    assign pop_dead    = !fifo_empty && !fifo_head.live;
    assign fifo_pop    = pop_live || pop_dead;
    assign head_killed = fifo_head.live && p_write && (fifo_head.addr == p_addr);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill_en    (p_write),
        .kill_addr  (p_addr),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .pend_mask  (pend_mask)
    );

    always_comb begin
        werf_d = 1'b0;
        wa_d   = '0;
        wd_d   = '0;
        if (p_write) begin
            werf_d = 1'b1;
            wa_d   = p_addr;
            wd_d   = p_data;
        end else if (pop_live) begin
            werf_d = 1'b1;
            wa_d   = fifo_head.addr;
            wd_d   = fifo_head.data;
        end
    end

    // The counter measures how long the current live head has been waiting;
    // it saturates at MAX_WAIT so stall holds while the primary keeps winning.
    always_comb begin
        starve_d = starve_q;
        if (!fifo_head.live || pop_live || head_killed) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(MAX_WAIT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        stall_d = (starve_d == STARVE_W'(MAX_WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            werf_q   <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            werf_q   <= werf_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign werf  = werf_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign stall = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        werf;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] pend_mask;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(
        .DEPTH    (4),
        .MAX_WAIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .werf      (werf),
        .wa        (wa),
        .wd        (wd),
        .stall     (stall),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 1'b0;
        p_addr  = '0;
        p_data  = '0;
        s_valid = 1'b0;
        s_addr  = '0;
        s_data  = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_werf",  {31'b0, werf}, 32'h0);
        chk("rst_wa",    {27'b0, wa}, 32'h0);
        chk("rst_wd",    wd, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_pend",  pend_mask, 32'h0);
        chk("rst_ready_after", {31'b0, s_ready}, 32'h1);

        // Primary write, latency 1, single-cycle pulse.
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        chk("pri_werf", {31'b0, werf}, 32'h1);
        chk("pri_wa",   {27'b0, wa}, 32'd5);
        chk("pri_wd",   wd, 32'hDEADBEEF);
        step();
        chk("pri_werf_drop", {31'b0, werf}, 32'h0);

        // Secondary with idle primary: latency 2.
        s_valid = 1'b1; s_addr = 5'd7; s_data = 32'h12;
        step();
        idle_inputs();
        chk("sec_pend", pend_mask, 32'h80);
        chk("sec_werf_early", {31'b0, werf}, 32'h0);
        step();
        chk("sec_werf", {31'b0, werf}, 32'h1);
        chk("sec_wa",   {27'b0, wa}, 32'd7);
        chk("sec_wd",   wd, 32'h12);
        chk("sec_pend_clear", pend_mask, 32'h0);

        // Fill with primary busy, then drain in order.
        p_valid = 1'b1; p_addr = 5'd20; p_data = 32'h2020;
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_addr = 5'(i); s_data = 32'h100 + i;
            step();
            chk("fill_pri_wa", {27'b0, wa}, 32'd20);
        end
        idle_inputs();
        chk("full_ready", {31'b0, s_ready}, 32'h0);
        chk("full_pend",  pend_mask, 32'h1E);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("drain_werf", {31'b0, werf}, 32'h1);
            chk("drain_wa",   {27'b0, wa}, i);
            chk("drain_wd",   wd, 32'h100 + i);
            chk("drain_ready", {31'b0, s_ready}, 32'h1);
        end
        step();
        chk("drain_done", {31'b0, werf}, 32'h0);
        chk("drain_pend", pend_mask, 32'h0);

        // WAW kill of a queued entry.
        s_valid = 1'b1; s_addr = 5'd9; s_data = 32'h55;
        step();
        idle_inputs();
        p_valid = 1'b1; p_addr = 5'd9; p_data = 32'hAA;
        chk("waw_pend_set", pend_mask, 32'h200);
        step();
        idle_inputs();
        chk("waw_pend_clr", pend_mask, 32'h0);
        chk("waw_werf", {31'b0, werf}, 32'h1);
        chk("waw_wa",   {27'b0, wa}, 32'd9);
        chk("waw_wd",   wd, 32'hAA);
        step();
        chk("waw_silent_pop", {31'b0, werf}, 32'h0);
        step();
        chk("waw_no_write", {31'b0, werf}, 32'h0);

        // WAW kill of an entry enqueued at the same edge.
        p_valid = 1'b1; p_addr = 5'd11; p_data = 32'hB1;
        s_valid = 1'b1; s_addr = 5'd11; s_data = 32'hB2;
        step();
        idle_inputs();
        chk("same_pend", pend_mask, 32'h0);
        chk("same_wd",   wd, 32'hB1);
        step();
        chk("same_silent", {31'b0, werf}, 32'h0);
        step();
        chk("same_no_write", {31'b0, werf}, 32'h0);

        // Starvation: secondary waits behind continuous primary.
        p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h33;
        s_valid = 1'b1; s_addr = 5'd12; s_data = 32'hC0;
        step();
        s_valid = 1'b0; s_addr = '0; s_data = '0;
        for (int i = 0; i < 7; i++) step();
        chk("stall_before", {31'b0, stall}, 32'h0);
        step();
        chk("stall_set", {31'b0, stall}, 32'h1);
        step();
        chk("stall_advisory_wa", {27'b0, wa}, 32'd3);
        chk("stall_held", {31'b0, stall}, 32'h1);
        idle_inputs();
        step();
        chk("stall_drain_werf", {31'b0, werf}, 32'h1);
        chk("stall_drain_wa",   {27'b0, wa}, 32'd12);
        chk("stall_drain_wd",   wd, 32'hC0);
        chk("stall_clear",      {31'b0, stall}, 32'h0);

        // Writes to x0 on both ports.
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hFFFF;
        s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hEEEE;
        step();
        chk("x0_werf1", {31'b0, werf}, 32'h0);
        chk("x0_pend",  pend_mask, 32'h0);
        idle_inputs();
        step();
        chk("x0_werf2", {31'b0, werf}, 32'h0);

        // Reset mid-operation with 3 entries queued.
        p_valid = 1'b1; p_addr = 5'd25; p_data = 32'h25;
        for (int i = 13; i <= 15; i++) begin
            s_valid = 1'b1; s_addr = 5'(i); s_data = 32'h200 + i;
            step();
        end
        idle_inputs();
        chk("mid_pend", pend_mask, 32'hE000);
        rst = 1'b1;
        step();
        chk("mid_rst_ready", {31'b0, s_ready}, 32'h0);
        chk("mid_rst_pend",  pend_mask, 32'h0);
        chk("mid_rst_werf",  {31'b0, werf}, 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_ready", {31'b0, s_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_write", {31'b0, werf}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
